// File: rtl/sr_flag_bank.sv
// Bank of clocked set/reset flags with optional edge-triggered set and minimum hold time.
// Each channel also keeps a saturating count of how often it has been raised.
module sr_flag_bank #(
   parameter int CHANNELS     = 4,
   parameter int SET_DOMINANT = 1,
   parameter int EDGE_SET     = 0,
   parameter int HOLD_CYCLES  = 0,
   parameter int CNT_W        = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       set,
   input  logic [CHANNELS-1:0]       clr,
   output logic [CHANNELS-1:0]       q,
   output logic [CHANNELS-1:0]       rise,
   output logic                      any,
   output logic [CHANNELS*CNT_W-1:0] raise_cnt
);

   // $clog2(1) is 0, so a zero hold still gets a one-bit counter.
   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [CHANNELS-1:0] q_q, q_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] set_prev_q, set_prev_d;
   logic [HW-1:0]       hold_q [CHANNELS];
   logic [HW-1:0]       hold_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q  [CHANNELS];
   logic [CNT_W-1:0]    cnt_d  [CHANNELS];

   logic [CHANNELS-1:0] set_evt;
   logic [CHANNELS-1:0] clr_eff;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      set_prev_d = set;
      set_evt    = '0;
      clr_eff    = '0;
      q_d        = q_q;
      rise_d     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hold_d[i] = hold_q[i];
         cnt_d[i]  = cnt_q[i];

         set_evt[i] = (EDGE_SET != 0) ? (set[i] & ~set_prev_q[i]) : set[i];
         clr_eff[i] = clr[i] & (hold_q[i] == '0);

         if (set_evt[i] && clr_eff[i]) begin
            q_d[i] = (SET_DOMINANT != 0);
         end else if (set_evt[i]) begin
            q_d[i] = 1'b1;
         end else if (clr_eff[i]) begin
            q_d[i] = 1'b0;
         end

         // A set event (even while already high) restarts the hold window.
         if (!q_d[i]) begin
            hold_d[i] = '0;
         end else if (set_evt[i]) begin
            hold_d[i] = HOLD_LOAD;
         end else if (hold_q[i] != '0) begin
            hold_d[i] = hold_q[i] - HW'(1);
         end

         rise_d[i] = q_d[i] & ~q_q[i];
         if (rise_d[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // The previous-set sample tracks the input even during reset, so a set held
   // across reset release is not seen as a fresh edge.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      set_prev_q <= set_prev_d;
   end

   // NOTE: the hold and count arrays are ordinary flops, reset along with the flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= '0;
         rise_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            hold_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         for (int i = 0; i < CHANNELS; i++) begin
            hold_q[i] <= hold_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   always_comb begin
      raise_cnt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         raise_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign any  = |q_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Scoreboard bench for sr_flag_bank: three parameterisations driven side by side,
// expected outputs queued with the stimulus and compared one edge later.
module tb_sr_flag_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] set_a, clr_a, set_b, clr_b, set_c, clr_c;
   logic [3:0] q_a, q_b, q_c, rise_a, rise_b, rise_c;
   logic       any_a, any_b, any_c;
   logic [31:0] cnt_a, cnt_c;
   logic [7:0]  cnt_b;

   // a: defaults (set-dominant, level, no hold, 8-bit counts)
   sr_flag_bank u_a (
      .clk(clk), .reset(reset), .set(set_a), .clr(clr_a),
      .q(q_a), .rise(rise_a), .any(any_a), .raise_cnt(cnt_a));

   // b: clear-dominant, edge-triggered set, 2-bit counts
   sr_flag_bank #(.SET_DOMINANT(0), .EDGE_SET(1), .HOLD_CYCLES(0), .CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .set(set_b), .clr(clr_b),
      .q(q_b), .rise(rise_b), .any(any_b), .raise_cnt(cnt_b));

   // c: level set with a three-cycle hold
   sr_flag_bank #(.SET_DOMINANT(1), .EDGE_SET(0), .HOLD_CYCLES(3), .CNT_W(8)) u_c (
      .clk(clk), .reset(reset), .set(set_c), .clr(clr_c),
      .q(q_c), .rise(rise_c), .any(any_c), .raise_cnt(cnt_c));

   typedef struct {
      string      tag;
      int         dut;
      logic [3:0] q;
      logic [3:0] rise;
      int         ch;
      int         cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input string tag, input int dut, input logic [3:0] q,
                           input logic [3:0] rise, input int ch, input int cnt);
      exp_t e;
      e.tag = tag; e.dut = dut; e.q = q; e.rise = rise; e.ch = ch; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t       e;
      logic [3:0] aq, ar;
      logic       aa;
      int         ac;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.dut)
            0:       begin aq = q_a; ar = rise_a; aa = any_a; ac = int'(cnt_a[e.ch*8 +: 8]); end
            1:       begin aq = q_b; ar = rise_b; aa = any_b; ac = int'(cnt_b[e.ch*2 +: 2]); end
            default: begin aq = q_c; ar = rise_c; aa = any_c; ac = int'(cnt_c[e.ch*8 +: 8]); end
         endcase
         check($sformatf("%s.q", e.tag),    32'(aq), 32'(e.q));
         check($sformatf("%s.rise", e.tag), 32'(ar), 32'(e.rise));
         check($sformatf("%s.any", e.tag),  32'(aa), 32'(|e.q));
         check($sformatf("%s.cnt%0d", e.tag, e.ch), 32'(ac), 32'(e.cnt));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      set_a = '0; clr_a = '0; set_b = 4'b0100; clr_b = '0; set_c = '0; clr_c = '0;

      // Reset state, with b.set[2] already high
      tick();
      push_exp("rst_a", 0, 4'b0000, 4'b0000, 0, 0);
      push_exp("rst_b", 1, 4'b0000, 4'b0000, 2, 0);
      push_exp("rst_c", 2, 4'b0000, 4'b0000, 0, 0);
      tick();

      // Set held through reset release must not register as an edge
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push_exp("edge_thru_rst", 1, 4'b0000, 4'b0000, 2, 0);
         tick();
      end

      // Level set then clear on a
      set_a = 4'b0001;
      push_exp("lvl_set", 0, 4'b0001, 4'b0001, 0, 1);
      tick();
      set_a = 4'b0000;
      push_exp("lvl_hold", 0, 4'b0001, 4'b0000, 0, 1);
      tick();
      clr_a = 4'b0001;
      push_exp("lvl_clr", 0, 4'b0000, 4'b0000, 0, 1);
      tick();
      clr_a = 4'b0000;

      // Coincident set/clear: set wins on a, clear wins on b
      set_a = 4'b0010; clr_a = 4'b0010;
      push_exp("sd1_both", 0, 4'b0010, 4'b0010, 1, 1);
      set_b = 4'b0110; clr_b = 4'b0010;
      push_exp("sd0_both", 1, 4'b0000, 4'b0000, 1, 0);
      tick();
      set_a = 4'b0000;
      push_exp("sd1_clr", 0, 4'b0000, 4'b0000, 1, 1);
      set_b = 4'b0000; clr_b = 4'b0000;
      push_exp("edge_low", 1, 4'b0000, 4'b0000, 2, 0);
      tick();
      clr_a = 4'b0000;

      // Edge mode: ten cycles of set high give one rise
      set_b = 4'b0100;
      push_exp("edge_rise", 1, 4'b0100, 4'b0100, 2, 1);
      tick();
      for (int k = 0; k < 9; k++) begin
         push_exp("edge_level", 1, 4'b0100, 4'b0000, 2, 1);
         tick();
      end
      set_b = 4'b0000; clr_b = 4'b0100;
      push_exp("edge_clr", 1, 4'b0000, 4'b0000, 2, 1);
      tick();
      clr_b = 4'b0000;

      // Saturating 2-bit count on b channel 3
      for (int n = 1; n <= 5; n++) begin
         set_b = 4'b1000; clr_b = 4'b0000;
         push_exp($sformatf("sat_set%0d", n), 1, 4'b1000, 4'b1000, 3, (n > 3) ? 3 : n);
         tick();
         set_b = 4'b0000; clr_b = 4'b1000;
         push_exp($sformatf("sat_clr%0d", n), 1, 4'b0000, 4'b0000, 3, (n > 3) ? 3 : n);
         tick();
      end
      clr_b = 4'b0000;

      // Hold of 3: clear held from k+1 takes effect at k+4
      set_c = 4'b0001;
      push_exp("hold_set", 2, 4'b0001, 4'b0001, 0, 1);
      tick();
      set_c = 4'b0000; clr_c = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         push_exp($sformatf("hold_k%0d", k), 2, 4'b0001, 4'b0000, 0, 1);
         tick();
      end
      push_exp("hold_fall", 2, 4'b0000, 4'b0000, 0, 1);
      tick();
      clr_c = 4'b0000;

      // Re-set at k+2 restarts the hold: fall moves to k+6, no second rise
      set_c = 4'b0001;
      push_exp("rehold_set", 2, 4'b0001, 4'b0001, 0, 2);
      tick();
      set_c = 4'b0000; clr_c = 4'b0001;
      push_exp("rehold_k1", 2, 4'b0001, 4'b0000, 0, 2);
      tick();
      set_c = 4'b0001;
      push_exp("rehold_k2", 2, 4'b0001, 4'b0000, 0, 2);
      tick();
      set_c = 4'b0000;
      for (int k = 3; k <= 5; k++) begin
         push_exp($sformatf("rehold_k%0d", k), 2, 4'b0001, 4'b0000, 0, 2);
         tick();
      end
      push_exp("rehold_fall", 2, 4'b0000, 4'b0000, 0, 2);
      tick();
      clr_c = 4'b0000;

      // Reset in the middle of a hold, with set still high
      set_c = 4'b0001;
      push_exp("mid_set", 2, 4'b0001, 4'b0001, 0, 3);
      tick();
      reset = 1'b1;
      push_exp("mid_rst_c", 2, 4'b0000, 4'b0000, 0, 0);
      push_exp("mid_rst_a", 0, 4'b0000, 4'b0000, 0, 0);
      push_exp("mid_rst_b", 1, 4'b0000, 4'b0000, 3, 0);
      tick();
      reset = 1'b0;
      push_exp("post_rst", 2, 4'b0001, 4'b0001, 0, 1);
      tick();
      set_c = 4'b0000;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sr_flag_bank.md
# sr_flag_bank

Parametrised bank of synchronous set/reset flags for the VGA design. Each channel captures a set request (level or rising edge), holds it until an explicit clear, enforces a minimum asserted time, and counts how many times it has been raised. Status producers (sync-lost, frame-done, button events) drive the bank. Display and control logic read the bank and clear it. It replaces free-running level latches with a fully clocked, glitch-free register stage.

## Interface
Parameters:
- CHANNELS, 4: number of independent flags.
- SET_DOMINANT, 1: 1 = set wins when set and clear coincide; 0 = clear wins.
- EDGE_SET, 0: 0 = set is level-sensitive; 1 = only a 0→1 transition of set raises the flag.
- HOLD_CYCLES, 0: minimum extra cycles the flag stays high after being raised, during which clear is ignored. Range 0..255.
- CNT_W, 8: width of each per-channel raise counter.

Ports:
- clk  in  1  single clock for all state.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- set  in  CHANNELS  per-channel set request.
- clr  in  CHANNELS  per-channel clear request.
- q  out  CHANNELS  registered flag state.
- rise  out  CHANNELS  registered one-cycle pulse in the first cycle q[i] is high after being low.
- any  out  1  OR of all q bits; combinational from the q registers.
- raise_cnt  out  CHANNELS*CNT_W  per-channel saturating count of rise events. Channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Per-channel state: q, set_d (previous set sample), hold_cnt (width clog2(HOLD_CYCLES+1), min 1), raise_cnt.
- set_evt = EDGE_SET ? (set & ~set_d) : set. set_d <= set every cycle, including during reset.
- hold_act = (hold_cnt != 0). Effective clear clr_eff = clr & ~hold_act.
- Next q:
  - if set_evt & clr_eff: next q = SET_DOMINANT.
  - else if set_evt: next q = 1.
  - else if clr_eff: next q = 0.
  - else: q holds.
- hold_cnt:
  - loads HOLD_CYCLES whenever next q = 1 because of set_evt. This includes re-sets while already high, which restart the hold.
  - otherwise decrements while nonzero.
  - forced to 0 whenever next q = 0.
- rise <= next q & ~q.
- raise_cnt increments on each rise and saturates at 2^CNT_W-1, with no wrap. It is cleared only by reset; clr does not affect it.
- Channels are fully independent. There is no cross-channel priority.
- Reset (synchronous) sets q=0, rise=0, hold_cnt=0 and raise_cnt=0, so any=0. set_d loads the live set value, so a set held high across reset release produces no edge when EDGE_SET=1.
- Reset overrides set/clr in the same cycle. Reset asserted mid-hold aborts the hold immediately.

## Timing
- Latency: a set/clr sampled at edge k is visible on q after edge k. rise is high for exactly the cycle following edge k. raise_cnt updates after the same edge k.
- Minimum high time: a flag raised at edge k cannot be cleared before edge k+HOLD_CYCLES+1. q is therefore high for at least HOLD_CYCLES+1 cycles.
- clr asserted during hold is dropped, not queued. It must still be high at or after edge k+HOLD_CYCLES+1 to take effect.
- With HOLD_CYCLES=0, set and clear one cycle apart produce a single-cycle q pulse.
- any follows q combinationally, with no added register. rise and q are both registered, so they are glitch-free.

## Test plan
- Reset, level mode, set[0]=1 for one cycle → q=0001 and rise=0001 for one cycle, raise_cnt[0]=1. Then clr[0]=1 for one cycle → q=0000, raise_cnt[0] remains 1.
- Coincident set[1]=clr[1]=1 with q[1]=0: SET_DOMINANT=1 → q[1]=1. SET_DOMINANT=0 → q[1]=0, rise[1]=0.
- EDGE_SET=1:
  - set[2] held high for 10 cycles → exactly one rise[2] pulse, raise_cnt[2]=1.
  - set[2] already high through reset release → no rise[2].
- HOLD_CYCLES=3:
  - set[0] at edge k, clr[0] held high from edge k+1 → q[0] falls after edge k+4, giving 4 high cycles.
  - A second set[0] at edge k+2 → fall moves to after edge k+6. No second rise pulse.
- CNT_W=2: raise channel 3 five times → raise_cnt[3] reads 1,2,3,3,3 (saturates at 3).
- Reset asserted mid-hold with set=1 → q=0, raise_cnt=0 after that edge. First post-reset cycle with set=1 in level mode → q=1, raise_cnt=1.
